// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed seven-segment display driver. Holds NUM_DIGITS hex digits,
// decodes the digit of the current slot to segments and scans the digit
// selects one slot at a time. Each slot lasts CLK_DIV cycles. The first
// DEAD_CYC cycles of every slot keep everything dark, so the shared segment
// bus can settle while the digit select changes.
//
// New data is captured into a shadow set on load_i. It is copied to the
// displayed (active) set only when the scan wraps back to digit 0, so a frame
// never shows a mix of old and new digits.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   en_i      scan enable; when low, the display is dark and the scan position holds
//   load_i    capture digits_i / dp_i / blank_i into the shadow set
//   digits_i  nibble k is digit k; digit 0 is the rightmost digit
//   dp_i      decimal point per digit
//   blank_i   force a digit dark
//   lzs_i     leading-zero suppression enable
//   seg_o     segments a..g on bits 6..0
//   dp_o      decimal-point segment
//   an_o      digit selects: one-hot active, or all inactive
//   frame_o   one-cycle pulse on the first output cycle of slot 0
//
// All outputs are registered. They appear one cycle after the (cnt, idx,
// active) state they are computed from.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_DIV        = 50000,
    parameter int DEAD_CYC       = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic                    lzs_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(CLK_DIV);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_V  = CNT_W'(DEAD_CYC);

    // Off levels at the pins. An active-high value XORed with these gives the
    // pin level for the configured polarity.
    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                               : {NUM_DIGITS{1'b0}};

    // Scan position
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    // Shadow (loaded) and active (displayed) data sets
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic                    pending;

    logic [4*NUM_DIGITS-1:0] act_digits;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_blank;

    // Selection and decode of the current slot
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_above;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [3:0]            cur_digit;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  cur_lz;
    logic                  cur_dark;
    logic [6:0]            cur_seg;

    logic slot_end;
    logic frame_wrap;

    // Active-high hex glyphs, a on bit 6 through g on bit 0
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // lz_mask[k] is set when digit k and every digit above it are zero.
    // Digit 0 is never included, so a value of zero still shows one "0".
    always_comb begin
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (act_digits[4*k +: 4] == 4'h0);
            if (k > 0) begin
                lz_mask[k] = zero_above;
            end
        end
    end

    // Select the digit for the current slot.
    always_comb begin
        an_sel    = '0;
        cur_digit = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        cur_lz    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                an_sel[k] = 1'b1;
                cur_digit = act_digits[4*k +: 4];
                cur_dp    = act_dp[k];
                cur_blank = act_blank[k];
                cur_lz    = lz_mask[k];
            end
        end
    end

    assign cur_dark   = cur_blank | (lzs_i & cur_lz);
    assign cur_seg    = cur_dark ? 7'h00 : hex_to_seg(cur_digit);
    assign slot_end   = (cnt == CNT_MAX);
    assign frame_wrap = en_i & slot_end & (idx == IDX_MAX);

    // Scan counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en_i) begin
            // Hold the slot and restart it from the beginning, including a
            // full dead time, when scanning resumes.
            cnt <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Shadow and active data sets. A load in the wrap cycle goes straight to
    // the active set, so it is shown in the frame that is starting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_blank   <= '1;
            pending    <= 1'b0;
            act_digits <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
        end else begin
            if (load_i) begin
                sh_digits <= digits_i;
                sh_dp     <= dp_i;
                sh_blank  <= blank_i;
                pending   <= 1'b1;
            end
            if (frame_wrap) begin
                if (load_i) begin
                    act_digits <= digits_i;
                    act_dp     <= dp_i;
                    act_blank  <= blank_i;
                    pending    <= 1'b0;
                end else if (pending) begin
                    act_digits <= sh_digits;
                    act_dp     <= sh_dp;
                    act_blank  <= sh_blank;
                    pending    <= 1'b0;
                end
            end
        end
    end

    // Registered pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o   <= SEG_OFF;
            dp_o    <= DP_OFF;
            an_o    <= AN_OFF;
            frame_o <= 1'b0;
        end else if (!en_i) begin
            seg_o   <= SEG_OFF;
            dp_o    <= DP_OFF;
            an_o    <= AN_OFF;
            frame_o <= 1'b0;
        end else begin
            frame_o <= (cnt == '0) && (idx == '0);
            if (cnt >= DEAD_V) begin
                an_o  <= an_sel ^ AN_OFF;
                seg_o <= cur_seg ^ SEG_OFF;
                dp_o  <= (cur_dp & ~cur_dark) ^ DP_OFF;
            end else begin
                an_o  <= AN_OFF;
                seg_o <= SEG_OFF;
                dp_o  <= DP_OFF;
            end
        end
    end

endmodule
